seg_rx: RTL

Serial receiver for the seven-segment display link: the far end of the SEG_CLK/SEG_DT/SEG_CLR/SEG_EN interface. It oversamples the link on the system clock, assembles each 64-bit frame of segment bytes and decodes each byte back to a hex nibble. Its main uses are:
- loopback checking of the display driver on the board;
- mirroring the displayed value into logic (for example the score or state readback in the game top level).

---
 rtl/seg_rx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_rx.sv
// seg_rx: oversampling receiver for the SEG_CLK/SEG_DT/SEG_CLR/SEG_EN display link.
// Define SEG_RX_DECODE_EN to build the glyph decoder; otherwise num/bad/dp read as zero.
module seg_rx #(
  parameter int FRAME_BITS = 64,
  parameter int IDLE_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seg_clk,
  input  logic                    seg_dt,
  input  logic                    seg_clr,
  input  logic                    seg_en,
  output logic [FRAME_BITS-1:0]   frame,
  output logic [FRAME_BITS/2-1:0] num,
  output logic [FRAME_BITS/8-1:0] bad,
  output logic [FRAME_BITS/8-1:0] dp,
  output logic                    valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int DIGITS = FRAME_BITS / 8;
  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       IDLE_MAX = 8'(IDLE_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CLOSE = 2'd2
  } state_t;

  logic [2:0] clk_sync_r;
  logic [1:0] dt_sync_r;
  logic [1:0] clr_sync_r;
  logic [1:0] en_sync_r;

  state_t                state_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic [FRAME_BITS-1:0] frame_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [7:0]            idle_r;
  logic                  valid_r;
  logic                  err_r;

  logic             edge_s;
  logic             dt_s;
  logic             clr_s;
  logic             en_s;
  logic             close_s;
  logic             load_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Two-flop synchronizers; the third seg_clk stage feeds the rising-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r <= 3'b000;
      dt_sync_r  <= 2'b00;
      clr_sync_r <= 2'b00;
      en_sync_r  <= 2'b00;
    end else begin
      clk_sync_r <= {clk_sync_r[1:0], seg_clk};
      dt_sync_r  <= {dt_sync_r[0], seg_dt};
      clr_sync_r <= {clr_sync_r[0], seg_clr};
      en_sync_r  <= {en_sync_r[0], seg_en};
    end
  end

  assign edge_s    = clk_sync_r[1] & ~clk_sync_r[2];
  assign dt_s      = dt_sync_r[1];
  assign clr_s     = clr_sync_r[1];
  assign en_s      = en_sync_r[1];
  assign cnt_inc_s = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CNT_ONE;
  assign close_s   = (state_r == RECV) && (idle_r == IDLE_MAX) && (cnt_r != CNT_ZERO) && clr_s && en_s;
  assign load_s    = close_s && (cnt_r == CNT_FULL);

  // Receive FSM: shifting, bit/idle counting, frame close and the valid/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shift_r <= {FRAME_BITS{1'b0}};
      frame_r <= {FRAME_BITS{1'b0}};
      cnt_r   <= CNT_ZERO;
      idle_r  <= 8'd0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      if (!clr_s) begin
        shift_r <= {FRAME_BITS{1'b0}};
        cnt_r   <= CNT_ZERO;
        idle_r  <= 8'd0;
        state_r <= IDLE;
      end else if (!en_s) begin
        cnt_r   <= CNT_ZERO;
        state_r <= IDLE;
        if (idle_r != IDLE_MAX) idle_r <= idle_r + 8'd1;
      end else begin
        if (edge_s) begin
          shift_r <= {shift_r[FRAME_BITS-2:0], dt_s};
          idle_r  <= 8'd0;
        end else if (idle_r != IDLE_MAX) begin
          idle_r <= idle_r + 8'd1;
        end
        if (close_s) begin
          // A coincident edge becomes bit 1 of the next frame.
          cnt_r   <= edge_s ? CNT_ONE : CNT_ZERO;
          state_r <= CLOSE;
          if (load_s) begin
            frame_r <= shift_r;
            valid_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
        end else begin
          if (edge_s) cnt_r <= cnt_inc_s;
          case (state_r)
            IDLE:    if (edge_s) state_r <= RECV;
            RECV:    state_r <= RECV;
            CLOSE:   state_r <= (edge_s || (cnt_r != CNT_ZERO)) ? RECV : IDLE;
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  assign frame     = frame_r;
  assign valid     = valid_r;
  assign frame_err = err_r;
  assign busy      = (cnt_r != CNT_ZERO);

`ifdef SEG_RX_DECODE_EN
  // Active-low {g..a} pattern to {bad, nibble}; dp is masked off by the caller.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h10:   res = 5'h09;
      7'h08:   res = 5'h0A;
      7'h03:   res = 5'h0B;
      7'h46:   res = 5'h0C;
      7'h21:   res = 5'h0D;
      7'h06:   res = 5'h0E;
      7'h0E:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  logic [FRAME_BITS/2-1:0] num_nxt_s;
  logic [DIGITS-1:0]       bad_nxt_s;
  logic [DIGITS-1:0]       dp_nxt_s;
  logic [FRAME_BITS/2-1:0] num_r;
  logic [DIGITS-1:0]       bad_r;
  logic [DIGITS-1:0]       dp_r;

  // Decode every digit of the shift register ahead of the close cycle.
  always_comb begin
    num_nxt_s = {(FRAME_BITS/2){1'b0}};
    bad_nxt_s = {DIGITS{1'b0}};
    dp_nxt_s  = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      {bad_nxt_s[i], num_nxt_s[4*i +: 4]} = decode_glyph(shift_r[8*i +: 7]);
      dp_nxt_s[i] = ~shift_r[8*i+7];
    end
  end

  // Decoded outputs load together with frame on a good close.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_r <= {(FRAME_BITS/2){1'b0}};
      bad_r <= {DIGITS{1'b0}};
      dp_r  <= {DIGITS{1'b0}};
    end else if (load_s) begin
      num_r <= num_nxt_s;
      bad_r <= bad_nxt_s;
      dp_r  <= dp_nxt_s;
    end else begin
      num_r <= num_r;
      bad_r <= bad_r;
      dp_r  <= dp_r;
    end
  end

  assign num = num_r;
  assign bad = bad_r;
  assign dp  = dp_r;
`else
  assign num = {(FRAME_BITS/2){1'b0}};
  assign bad = {DIGITS{1'b0}};
  assign dp  = {DIGITS{1'b0}};
`endif

endmodule
